// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes, FSM states and sizing helper for the AXI4-Lite slave
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_e;

  // A single register still needs a one-bit index.
  function automatic int idx_width(input int num_regs);
    return (num_regs <= 1) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// rtl/axi4_lite_addr_decode.sv - maps a byte address onto a register index, hit flag and read-only flag
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int                        ADDRESS_WIDTH = 32,
  parameter int                        DATA_WIDTH    = 32,
  parameter int                        NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0]  BASE_ADDR     = '0,
  parameter logic [NUM_REGS-1:0]       RO_MASK       = '0
) (
  input  logic [ADDRESS_WIDTH-1:0]          i_addr,
  output logic [idx_width(NUM_REGS)-1:0]    o_index,
  output logic                              o_hit,
  output logic                              o_read_only
);

  localparam int IDX_W = idx_width(NUM_REGS);
  localparam int LSB   = $clog2(DATA_WIDTH / 8);

  logic [ADDRESS_WIDTH-1:0] w_offset;
  logic [ADDRESS_WIDTH-1:0] w_word;

  always_comb begin
    w_offset    = i_addr - BASE_ADDR;
    w_word      = w_offset >> LSB;
    o_hit       = (i_addr >= BASE_ADDR) && (w_word < ADDRESS_WIDTH'(NUM_REGS));
    o_index     = w_word[IDX_W-1:0];
    o_read_only = o_hit && RO_MASK[o_index];
  end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// rtl/axi4_lite_reg_slave.sv - AXI4-Lite register bank with byte strobes, RO registers and error responses
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int                        DATA_WIDTH    = 32,
  parameter int                        ADDRESS_WIDTH = 32,
  parameter int                        NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0]  BASE_ADDR     = '0,
  parameter logic [NUM_REGS-1:0]       RO_MASK       = '0,
  parameter logic [DATA_WIDTH-1:0]     RESET_VALUE   = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDRESS_WIDTH-1:0]       S_AWADDR,
  input  logic                           S_AWVALID,
  output logic                           S_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
  input  logic                           S_WVALID,
  output logic                           S_WREADY,
  output logic [1:0]                     S_BRESP,
  output logic                           S_BVALID,
  input  logic                           S_BREADY,
  input  logic [ADDRESS_WIDTH-1:0]       S_ARADDR,
  input  logic                           S_ARVALID,
  output logic                           S_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_RDATA,
  output logic [1:0]                     S_RRESP,
  output logic                           S_RVALID,
  input  logic                           S_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_D,
  output logic [NUM_REGS-1:0]            WR_PULSE
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_width(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_reg_d;

  wstate_e                  r_wstate;
  logic                     r_awready;
  logic                     r_wready;
  logic                     r_bvalid;
  resp_e                    r_bresp;
  logic                     r_aw_have;
  logic                     r_w_have;
  logic [ADDRESS_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [STRB_W-1:0]        r_wstrb;
  logic [NUM_REGS-1:0]      r_wr_pulse;

  rstate_e                  r_rstate;
  logic                     r_arready;
  logic                     r_rvalid;
  resp_e                    r_rresp;
  logic [DATA_WIDTH-1:0]    r_rdata;

  logic                     w_aw_fire;
  logic                     w_w_fire;
  logic                     w_commit;
  logic [ADDRESS_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic [STRB_W-1:0]        w_wr_strb;
  logic [IDX_W-1:0]         w_wr_idx;
  logic                     w_wr_hit;
  logic                     w_wr_ro;
  logic [IDX_W-1:0]         w_rd_idx;
  logic                     w_rd_hit;
  logic                     w_rd_ro;

  assign w_aw_fire = S_AWVALID && r_awready;
  assign w_w_fire  = S_WVALID && r_wready;
  // Whichever half arrives second is taken straight from the bus so the commit lands on its edge.
  assign w_wr_addr = r_aw_have ? r_awaddr : S_AWADDR;
  assign w_wr_data = r_w_have ? r_wdata : S_WDATA;
  assign w_wr_strb = r_w_have ? r_wstrb : S_WSTRB;
  assign w_commit  = (r_wstate == W_COLLECT) && (r_aw_have || w_aw_fire) && (r_w_have || w_w_fire);
  assign w_reg_d   = REG_D;

  axi4_lite_addr_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .BASE_ADDR     (BASE_ADDR),
    .RO_MASK       (RO_MASK)
  ) u_aw_decode (
    .i_addr      (w_wr_addr),
    .o_index     (w_wr_idx),
    .o_hit       (w_wr_hit),
    .o_read_only (w_wr_ro)
  );

  axi4_lite_addr_decode #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_REGS      (NUM_REGS),
    .BASE_ADDR     (BASE_ADDR),
    .RO_MASK       (RO_MASK)
  ) u_ar_decode (
    .i_addr      (S_ARADDR),
    .o_index     (w_rd_idx),
    .o_hit       (w_rd_hit),
    .o_read_only (w_rd_ro)
  );

  always_ff @(posedge ACLK) begin
    r_wr_pulse <= '0;
    if (ARESET) begin
      r_wstate  <= W_COLLECT;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_regs    <= {NUM_REGS{RESET_VALUE}};
    end else begin
      case (r_wstate)
        W_COLLECT: begin
          if (w_aw_fire) begin
            r_aw_have <= 1'b1;
            r_awaddr  <= S_AWADDR;
          end
          if (w_w_fire) begin
            r_w_have <= 1'b1;
            r_wdata  <= S_WDATA;
            r_wstrb  <= S_WSTRB;
          end
          if (w_commit) begin
            if (!w_wr_hit) begin
              r_bresp <= DECERR;
            end else if (w_wr_ro) begin
              r_bresp <= SLVERR;
            end else begin
              r_bresp <= OKAY;
              for (int b = 0; b < STRB_W; b++) begin
                if (w_wr_strb[b]) r_regs[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
              end
              r_wr_pulse[w_wr_idx] <= |w_wr_strb;
            end
            r_wstate  <= W_RESP;
            r_bvalid  <= 1'b1;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
          end else begin
            r_awready <= !(r_aw_have || w_aw_fire);
            r_wready  <= !(r_w_have || w_w_fire);
          end
        end
        W_RESP: begin
          if (S_BREADY) begin
            r_wstate  <= W_COLLECT;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_COLLECT;
      endcase
    end
  end

  // Reads see r_regs before any same-edge commit, so they return the pre-write value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (S_ARVALID && r_arready) begin
            r_rstate  <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            if (!w_rd_hit) begin
              r_rresp <= DECERR;
              r_rdata <= '0;
            end else if (w_rd_ro) begin
              r_rresp <= OKAY;
              r_rdata <= w_reg_d[w_rd_idx];
            end else begin
              r_rresp <= OKAY;
              r_rdata <= r_regs[w_rd_idx];
            end
          end
        end
        R_RESP: begin
          if (S_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AWREADY = r_awready;
  assign S_WREADY  = r_wready;
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = r_bresp;
  assign S_ARREADY = r_arready;
  assign S_RVALID  = r_rvalid;
  assign S_RRESP   = r_rresp;
  assign S_RDATA   = r_rdata;
  assign REG_Q     = r_regs;
  assign WR_PULSE  = r_wr_pulse;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// tb/tb_axi4_lite_reg_slave.sv - randomized self-checking bench for axi4_lite_reg_slave against a register-array model
module tb_axi4_lite_reg_slave;

  localparam int             DW = 32;
  localparam int             AW = 32;
  localparam int             NR = 16;
  localparam logic [NR-1:0]  RO = 16'h0208;
  localparam logic [DW-1:0]  RV = 32'h0;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NR*DW-1:0]  reg_q;
  logic [NR*DW-1:0]  reg_d;
  logic [NR-1:0]     wr_pulse;

  int                n_checks = 0;
  int                n_fail = 0;
  logic [DW-1:0]     m_regs [NR];
  logic [DW-1:0]     m_d [NR];
  logic [AW-1:0]     rnd_addr;

  axi4_lite_reg_slave #(
    .DATA_WIDTH (DW), .ADDRESS_WIDTH (AW), .NUM_REGS (NR),
    .BASE_ADDR (32'h0), .RO_MASK (RO), .RESET_VALUE (RV)
  ) dut (
    .ACLK (clk), .ARESET (rst),
    .S_AWADDR (awaddr), .S_AWVALID (awvalid), .S_AWREADY (awready),
    .S_WDATA (wdata), .S_WSTRB (wstrb), .S_WVALID (wvalid), .S_WREADY (wready),
    .S_BRESP (bresp), .S_BVALID (bvalid), .S_BREADY (bready),
    .S_ARADDR (araddr), .S_ARVALID (arvalid), .S_ARREADY (arready),
    .S_RDATA (rdata), .S_RRESP (rresp), .S_RVALID (rvalid), .S_RREADY (rready),
    .REG_Q (reg_q), .REG_D (reg_d), .WR_PULSE (wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      check($sformatf("%s reg_q[%0d]", tag, i), 64'(reg_q[i*DW +: DW]), 64'(m_regs[i]));
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input bit skip_b);
    bit            aw_done, w_done, aw_fire, w_fire;
    int            cyc, idx, hold;
    logic [1:0]    eresp;
    logic [NR-1:0] epulse;
    aw_done = 0; w_done = 0; cyc = 0;
    idx = int'(addr >> 2);
    epulse = '0;
    if (idx >= NR) eresp = 2'b11;
    else if (RO[idx]) eresp = 2'b10;
    else begin
      eresp = 2'b00;
      for (int b = 0; b < 4; b++) if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      if (strb != 4'h0) epulse[idx] = 1'b1;
    end
    while (!(aw_done && w_done)) begin
      @(negedge clk);
      if (w_done && !aw_done) check("wready_low_after_w", 64'(wready), 64'd0);
      if (aw_done && !w_done) check("awready_low_after_aw", 64'(awready), 64'd0);
      awaddr  = addr;
      awvalid = !aw_done && (cyc >= aw_dly);
      wdata   = data;
      wstrb   = strb;
      wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk);
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
      if (cyc > 40) begin
        check("write_handshake_timeout", 64'd1, 64'd0);
        awvalid = 0; wvalid = 0;
        return;
      end
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    check("bvalid_after_commit", 64'(bvalid), 64'd1);
    check("bresp", 64'(bresp), 64'(eresp));
    check("wr_pulse", 64'(wr_pulse), 64'(epulse));
    check_regs("after_write");
    if (skip_b) return;
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge clk);
      check("bvalid_hold", 64'(bvalid), 64'd1);
      check("bresp_hold", 64'(bresp), 64'(eresp));
      check("wr_pulse_one_cycle", 64'(wr_pulse), 64'd0);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    check("bvalid_clear", 64'(bvalid), 64'd0);
    check("wr_pulse_clear", 64'(wr_pulse), 64'd0);
    check("awready_back", 64'({awready, wready}), 64'd3);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int hold);
    bit            fired;
    int            cyc, idx;
    logic [DW-1:0] edata;
    logic [1:0]    eresp;
    fired = 0; cyc = 0;
    idx = int'(addr >> 2);
    if (idx >= NR) begin edata = '0; eresp = 2'b11; end
    else if (RO[idx]) begin edata = m_d[idx]; eresp = 2'b00; end
    else begin edata = m_regs[idx]; eresp = 2'b00; end
    while (!fired) begin
      @(negedge clk);
      araddr  = addr;
      arvalid = 1;
      fired   = arready;
      @(posedge clk);
      cyc++;
      if (cyc > 20) begin
        check("read_handshake_timeout", 64'd1, 64'd0);
        arvalid = 0;
        return;
      end
    end
    @(negedge clk);
    arvalid = 0;
    check("rvalid_after_ar", 64'(rvalid), 64'd1);
    check("rdata", 64'(rdata), 64'(edata));
    check("rresp", 64'(rresp), 64'(eresp));
    repeat (hold) begin
      @(negedge clk);
      check("rvalid_hold", 64'(rvalid), 64'd1);
      check("rdata_hold", 64'(rdata), 64'(edata));
      check("rresp_hold", 64'(rresp), 64'(eresp));
      check("arready_low_in_resp", 64'(arready), 64'd0);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    check("rvalid_clear", 64'(rvalid), 64'd0);
  endtask

  initial begin
    rst = 1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    for (int i = 0; i < NR; i++) begin
      m_d[i] = $urandom;
      if (i == 3) m_d[i] = 32'hCAFE0001;
      reg_d[i*DW +: DW] = m_d[i];
      m_regs[i] = RV;
    end

    repeat (3) @(negedge clk);
    check("reset_readies", 64'({awready, wready, arready}), 64'd0);
    check("reset_valids", 64'({bvalid, rvalid}), 64'd0);
    check("reset_resps", 64'({bresp, rresp}), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_wr_pulse", 64'(wr_pulse), 64'd0);
    check_regs("reset");
    rst = 0;
    @(negedge clk);
    check("readies_after_release", 64'({awready, wready, arready}), 64'd7);

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h4, 0);
    do_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'h8, 32'h11223344, 4'b0101, 3, 0, 0);
    check("strobe_merge", 64'(reg_q[2*DW +: DW]), 64'h00000000FF22FF44);
    do_write(32'hC, 32'h12345678, 4'hF, 0, 1, 0);
    do_read(32'hC, 1);
    do_read(32'h40, 0);
    do_write(32'h40, 32'h87654321, 4'hF, 1, 0, 0);
    do_write(32'h14, 32'hABCDEF01, 4'h0, 0, 0, 0);
    do_read(32'h4, 5);

    @(negedge clk);
    check("same_edge_readies", 64'({awready, wready, arready}), 64'd7);
    awaddr = 32'h0; awvalid = 1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h0; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    m_regs[0] = 32'h5;
    check("same_edge_rdata_old", 64'(rdata), 64'd0);
    check("same_edge_valids", 64'({bvalid, rvalid}), 64'd3);
    check("same_edge_reg_q", 64'(reg_q[0 +: DW]), 64'd5);
    bready = 1; rready = 1;
    @(negedge clk);
    bready = 0; rready = 0;
    check("same_edge_clear", 64'({bvalid, rvalid}), 64'd0);
    do_read(32'h0, 0);

    for (int k = 0; k < 30; k++) begin
      rnd_addr = AW'(($urandom_range(0, 17) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(rnd_addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      else
        do_read(rnd_addr, $urandom_range(0, 2));
    end

    do_write(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 1);
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) m_regs[i] = RV;
    check("reset_mid_bvalid", 64'(bvalid), 64'd0);
    check("reset_mid_readies", 64'({awready, wready, arready}), 64'd0);
    check_regs("reset_mid");
    rst = 0;
    @(negedge clk);
    check("readies_after_mid_reset", 64'({awready, wready, arready}), 64'd7);
    do_read(32'h10, 0);
    do_read(32'h4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
